gray_to_bin_pipe: RTL and testbench

- Pipelined Gray-to-binary decoder; the receive-side counterpart of the team's binary-to-Gray encoder.
- Typical use: decoding Gray-coded pointers and counters after they cross into the local domain.
- valid/ready streaming on both sides, one word per cycle, configurable pipeline depth.
- Optional step checker flags any accepted Gray word that differs from the previously accepted one in more than one bit.

---
 rtl/gray_pkg.sv | 58 +++++
 rtl/gray_dec_stage.sv | 61 ++++++
 rtl/gray_to_bin_pipe.sv | 89 ++++++++
 tb/tb_gray_to_bin_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared helpers for the pipelined Gray-to-binary decoder: slice decode,
// popcount and the per-stage bit-range derivation.
package gray_pkg;

    // Widest word the helpers handle; callers zero-extend into this width.
    localparam int GRAY_W = 64;

    function automatic int stage_bits(input int n, input int stages);
        return (n + stages - 1) / stages;
    endfunction

    // MSB of the range stage k resolves; negative means the stage resolves nothing.
    function automatic int stage_hi(input int n, input int stages, input int k);
        return n - 1 - k * stage_bits(n, stages);
    endfunction

    function automatic int stage_lo(input int n, input int stages, input int k);
        int lo;
        if (k == stages - 1) begin
            lo = 0;
        end else begin
            lo = stage_hi(n, stages, k) - stage_bits(n, stages) + 1;
            if (lo < 0) lo = 0;
        end
        return lo;
    endfunction

    // Bits above hi are already binary; bits hi..lo are turned from Gray into
    // binary, chaining from upper_bin_bit; bits below lo stay Gray.
    function automatic logic [GRAY_W-1:0] gray2bin_slice(
        input logic [GRAY_W-1:0] gray,
        input logic              upper_bin_bit,
        input int                lo,
        input int                hi
    );
        logic [GRAY_W-1:0] res;
        logic              b;
        res = gray;
        b   = upper_bin_bit;
        for (int i = GRAY_W - 1; i >= 0; i--) begin
            if (i <= hi && i >= lo) begin
                b      = b ^ gray[i];
                res[i] = b;
            end
        end
        return res;
    endfunction

    function automatic int popcount(input logic [GRAY_W-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < GRAY_W; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_dec_stage.sv
// One decoder pipeline stage: resolves Gray bits HI..LO of a partially
// decoded word and forwards it under valid/ready flow control.
module gray_dec_stage
    import gray_pkg::*;
#(
    parameter int N  = 16,
    parameter int HI = 15,
    parameter int LO = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [N-1:0] up_word,
    input  logic         up_err,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [N-1:0] dn_word,
    output logic         dn_err
);

    logic              vld_p;
    logic [N-1:0]      word_p;
    logic              err_p;
    logic              upper_bit;
    logic [GRAY_W-1:0] dec_full;
    logic              unused_dec;

    // The first stage (and any empty stage) has no resolved bit above it.
    if (HI < 0 || HI >= N - 1) begin : g_top
        assign upper_bit = 1'b0;
    end else begin : g_mid
        assign upper_bit = up_word[HI+1];
    end

    assign dec_full   = gray2bin_slice(GRAY_W'(up_word), upper_bit, LO, HI);
    assign unused_dec = ^dec_full;

    // A full stage may still load if its contents leave this same cycle.
    assign up_ready = !vld_p || dn_ready;

    // ---- stage register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= 1'b0;
            word_p <= '0;
            err_p  <= 1'b0;
        end else if (up_ready) begin
            vld_p <= up_valid;
            if (up_valid) begin
                word_p <= dec_full[N-1:0];
                err_p  <= up_err;
            end
        end
    end

    assign dn_valid = vld_p;
    assign dn_word  = word_p;
    assign dn_err   = err_p;

endmodule

// File: rtl/gray_to_bin_pipe.sv
// Pipelined Gray-to-binary decoder with valid/ready streaming and an optional
// single-bit-transition checker with saturating error counter.
module gray_to_bin_pipe
    import gray_pkg::*;
#(
    parameter int N          = 16,
    parameter int STAGES     = 2,
    parameter int CHECK_STEP = 1,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_gray,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_binary,
    output logic          out_step_err,
    output logic [CW-1:0] err_count
);

    // Index k is the input of stage k; index STAGES is the pipeline output.
    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [STAGES:0] err;
    logic [N-1:0]    word [STAGES+1];
    logic            step_err;

    assign vld[0]      = in_valid && !rst;
    assign word[0]     = in_gray;
    assign err[0]      = step_err;
    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0] && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        gray_dec_stage #(
            .N  (N),
            .HI (stage_hi(N, STAGES, k)),
            .LO (stage_lo(N, STAGES, k))
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (vld[k]),
            .up_ready (rdy[k]),
            .up_word  (word[k]),
            .up_err   (err[k]),
            .dn_valid (vld[k+1]),
            .dn_ready (rdy[k+1]),
            .dn_word  (word[k+1]),
            .dn_err   (err[k+1])
        );
    end

    assign out_valid    = vld[STAGES];
    assign out_binary   = word[STAGES];
    assign out_step_err = err[STAGES];

    if (CHECK_STEP != 0) begin : g_step
        logic [N-1:0]  last_gray;
        logic          have_last;
        logic [CW-1:0] err_cnt;
        logic          in_xfer;

        assign in_xfer  = in_valid && in_ready;
        assign step_err = have_last && (popcount(GRAY_W'(in_gray ^ last_gray)) > 1);

        // ---- checker state, advanced only on accepted words ----
        always_ff @(posedge clk) begin
            if (rst) begin
                last_gray <= '0;
                have_last <= 1'b0;
                err_cnt   <= '0;
            end else if (in_xfer) begin
                last_gray <= in_gray;
                have_last <= 1'b1;
                if (step_err && err_cnt != {CW{1'b1}}) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end

        assign err_count = err_cnt;
    end else begin : g_no_step
        assign step_err  = 1'b0;
        assign err_count = '0;
    end

endmodule

// File: tb/tb_gray_to_bin_pipe.sv
// Self-checking bench for gray_to_bin_pipe (N=8, STAGES=2, CW=4): directed
// scenarios plus a randomized stream, scored against a reference model.
module tb_gray_to_bin_pipe;

    localparam int N      = 8;
    localparam int STAGES = 2;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_gray;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_binary;
    logic          out_step_err;
    logic [CW-1:0] err_count;

    gray_to_bin_pipe #(
        .N          (N),
        .STAGES     (STAGES),
        .CHECK_STEP (1),
        .CW         (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_gray      (in_gray),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_binary   (out_binary),
        .out_step_err (out_step_err),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] exp_bin[$];
    logic         exp_err[$];
    int           m_cnt = 0;
    logic         have_last = 1'b0;
    logic [N-1:0] last_g = '0;
    int           n_out = 0;
    logic         last_ix = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [N-1:0] ref_bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b = '0;
        for (int k = 0; k < N; k++) b = b ^ (g >> k);
        return b;
    endfunction

    function automatic logic [N-1:0] to_gray(input int b);
        logic [N-1:0] v;
        v = N'(b);
        return v ^ (v >> 1);
    endfunction

    // Inputs are set at the falling edge before calling; one clock elapses.
    task automatic tick();
        logic ix;
        logic ox;
        logic e;
        #1;
        ix = in_valid && in_ready;
        ox = out_valid && out_ready;
        if (rst) begin
            check("in_ready_in_rst", 32'(in_ready), 32'd0);
            exp_bin.delete();
            exp_err.delete();
            have_last = 1'b0;
            last_g    = '0;
            m_cnt     = 0;
            ix        = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_bin.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    check("out_binary", 32'(out_binary), 32'(exp_bin[0]));
                    check("out_step_err", 32'(out_step_err), 32'(exp_err[0]));
                    if (ox) begin
                        void'(exp_bin.pop_front());
                        void'(exp_err.pop_front());
                        n_out++;
                    end
                end
            end
            if (ix) begin
                e = have_last && ($countones(in_gray ^ last_g) > 1);
                exp_bin.push_back(ref_bin(in_gray));
                exp_err.push_back(e);
                if (e && m_cnt < CMAX) m_cnt++;
                have_last = 1'b1;
                last_g    = in_gray;
            end
        end
        last_ix = ix;
        @(posedge clk);
        @(negedge clk);
        check("err_count", 32'(err_count), 32'(m_cnt));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_bin.size() != 0; i++) tick();
        check("drain_empty", 32'(exp_bin.size()), 32'd0);
    endtask

    initial begin
        int           bp_b;
        logic [N-1:0] cur_g;
        int           r;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_gray   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_binary", 32'(out_binary), 32'd0);
        check("rst_out_step_err", 32'(out_step_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;

        // Single word latency
        in_valid  = 1'b1;
        in_gray   = 8'hC5;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_t1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_t2_valid", 32'(out_valid), 32'd1);
        check("lat_t2_binary", 32'(out_binary), 32'h86);
        check("lat_t2_err", 32'(out_step_err), 32'd0);
        drain();

        // Full sweep, back-to-back
        do_reset();
        n_out     = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int b = 0; b < 256; b++) begin
            in_gray = to_gray(b);
            #1;
            check("sweep_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        drain();
        check("sweep_count", 32'(n_out), 32'd256);
        check("sweep_err_count", 32'(err_count), 32'd0);

        // Step error detection
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_gray = 8'h00; tick();
        in_gray = 8'h03; tick();
        in_gray = 8'h02; tick();
        drain();
        check("step_err_count", 32'(err_count), 32'd1);

        // Backpressure
        do_reset();
        bp_b      = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_gray = to_gray(bp_b);
            tick();
            if (last_ix) bp_b++;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_gray = to_gray(bp_b);
            tick();
            if (last_ix) bp_b++;
        end
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_held_words", 32'(exp_bin.size()), 32'(STAGES));
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_gray = to_gray(bp_b);
            tick();
            if (last_ix) bp_b++;
        end
        drain();

        // Reset with words in flight
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_gray = 8'h01; tick();
        in_gray = 8'h00; tick();
        check("mid_in_flight", 32'(exp_bin.size()), 32'd2);
        rst     = 1'b1;
        in_gray = 8'h55;
        tick();
        rst = 1'b0;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_err_count", 32'(err_count), 32'd0);
        in_gray   = 8'hFF;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_binary", 32'(out_binary), 32'hAA);
        check("post_rst_flag", 32'(out_step_err), 32'd0);
        drain();

        // Counter saturation
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_gray = (i % 2 == 0) ? 8'h00 : 8'h0F;
            tick();
            if (i == 16) check("sat_reached", 32'(err_count), 32'd15);
        end
        drain();
        check("sat_hold", 32'(err_count), 32'd15);

        // Randomized stream with random backpressure
        do_reset();
        cur_g = N'($urandom);
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       cur_g = cur_g ^ (N'(1) << $urandom_range(0, N - 1));
            else if (r == 9) cur_g = N'($urandom);
            in_gray   = cur_g;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
